// File: rtl/comms_bus_arbiter.sv
// comms_bus_arbiter
//   Two-requester round-robin arbiter in front of a single core access port.
//   The command path (a_*) and the stream path (b_*) each hold a request until
//   their done pulse. The winner's command is latched and presented to the
//   core for as long as it takes the core to acknowledge.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata     command-path request (held until a_done)
//   a_done/a_rdata                command-path completion pulse, read data
//   b_req/b_we/b_addr/b_wdata     stream-path request (held until b_done)
//   b_done/b_rdata                stream-path completion pulse, read data
//   core_en/core_we               core access strobe and write-enable
//   core_addr/core_wdata          core address and write data
//   core_ready/core_rdata         core acknowledge, read data in the same cycle
//   timeout_err                   sticky abort flag
//   timeout_clr                   clears timeout_err
//
// Configuration
//   COMMS_ARB_TIMEOUT_EN  when defined, an ACCESS that sees no core_ready for
//                         TIMEOUT_CYCLES cycles is aborted (reads return 0)
//                         and timeout_err is set. When undefined, ACCESS waits
//                         indefinitely, timeout_err is tied 0 and timeout_clr
//                         is ignored.
//
// state  | meaning
// IDLE   | waiting for a request; latches the winner's command
// ACCESS | core_en driven with the latched command until ready (or abort)
// DONE   | winner's done pulse visible; last_grant updated

module comms_bus_arbiter #(
  parameter int ADDRESS_WIDTH  = 24,
  parameter int VALUE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [VALUE_WIDTH-1:0]   a_wdata,
  output logic                     a_done,
  output logic [VALUE_WIDTH-1:0]   a_rdata,

  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [VALUE_WIDTH-1:0]   b_wdata,
  output logic                     b_done,
  output logic [VALUE_WIDTH-1:0]   b_rdata,

  output logic                     core_en,
  output logic                     core_we,
  output logic [ADDRESS_WIDTH-1:0] core_addr,
  output logic [VALUE_WIDTH-1:0]   core_wdata,
  input  logic                     core_ready,
  input  logic [VALUE_WIDTH-1:0]   core_rdata,

  output logic                     timeout_err,
  input  logic                     timeout_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  state_t state;
  logic   last_grant;
  logic   cur_grant;
  // Set for the single IDLE cycle that follows DONE. The path just served is
  // still holding req in that cycle (it only drops after seeing done), so its
  // request is masked there to avoid granting a stale request twice.
  logic   post_done;

  logic                   a_cand;
  logic                   b_cand;
  logic                   pick_b;
  logic                   finish;
  logic [VALUE_WIDTH-1:0] finish_data;

`ifdef COMMS_ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       timeout_hit;

  // wait_cnt counts completed ACCESS cycles without ready; the cycle in which
  // it would reach TIMEOUT_CYCLES is the abort cycle.
  assign timeout_hit = !core_ready && (wait_cnt == WAIT_LAST);
`else
  logic unused_timeout_clr;

  assign unused_timeout_clr = timeout_clr;
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    a_cand = a_req && !(post_done && (last_grant == GRANT_A));
    b_cand = b_req && !(post_done && (last_grant == GRANT_B));
    // Single candidate always wins; on a tie take the path not granted last.
    pick_b = b_cand && (!a_cand || (last_grant == GRANT_A));
`ifdef COMMS_ARB_TIMEOUT_EN
    finish = core_ready || timeout_hit;
`else
    finish = core_ready;
`endif
    // An aborted read returns zero rather than whatever is on core_rdata.
    finish_data = core_ready ? core_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_B;
      cur_grant  <= GRANT_A;
      post_done  <= 1'b0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      core_en    <= 1'b0;
      core_we    <= 1'b0;
      core_addr  <= '0;
      core_wdata <= '0;
`ifdef COMMS_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
`ifdef COMMS_ARB_TIMEOUT_EN
      // A set later in this block overrides the clear (set wins).
      if (timeout_clr) begin
        timeout_err <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          post_done <= 1'b0;
          if (a_cand || b_cand) begin
            cur_grant  <= pick_b;
            core_en    <= 1'b1;
            core_we    <= pick_b ? b_we    : a_we;
            core_addr  <= pick_b ? b_addr  : a_addr;
            core_wdata <= pick_b ? b_wdata : a_wdata;
`ifdef COMMS_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
            state      <= ACCESS;
          end
        end

        ACCESS: begin
          if (finish) begin
            core_en    <= 1'b0;
            core_we    <= 1'b0;
            core_addr  <= '0;
            core_wdata <= '0;
            if (!core_we) begin
              if (cur_grant == GRANT_B) begin
                b_rdata <= finish_data;
              end else begin
                a_rdata <= finish_data;
              end
            end
            if (cur_grant == GRANT_B) begin
              b_done <= 1'b1;
            end else begin
              a_done <= 1'b1;
            end
`ifdef COMMS_ARB_TIMEOUT_EN
            if (!core_ready) begin
              timeout_err <= 1'b1;
            end
`endif
            state <= DONE;
          end
`ifdef COMMS_ARB_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end

        DONE: begin
          last_grant <= cur_grant;
          post_done  <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comms_bus_arbiter.sv
// Directed bench for comms_bus_arbiter with a scoreboard of expected
// completions (path, rdata) pushed when a request is driven and popped when
// a done pulse appears.

module tb_comms_bus_arbiter;

  localparam int AW = 24;
  localparam int VW = 32;
  localparam int TO = 15;

  logic          clk;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [VW-1:0] a_wdata, b_wdata;
  logic          a_done, b_done;
  logic [VW-1:0] a_rdata, b_rdata;
  logic          core_en, core_we;
  logic [AW-1:0] core_addr;
  logic [VW-1:0] core_wdata;
  logic          core_ready;
  logic [VW-1:0] core_rdata;
  logic          timeout_err, timeout_clr;

  comms_bus_arbiter #(
    .ADDRESS_WIDTH (AW),
    .VALUE_WIDTH   (VW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_done     (a_done),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_done     (b_done),
    .b_rdata    (b_rdata),
    .core_en    (core_en),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ready (core_ready),
    .core_rdata (core_rdata),
    .timeout_err(timeout_err),
    .timeout_clr(timeout_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          path;   // 0 = A, 1 = B
    logic [VW-1:0] rdata;  // rdata expected on that path at done
  } sb_t;

  sb_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] exp_a_rdata = '0;
  logic [VW-1:0] exp_b_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input bit path, input bit on, input bit we,
                           input logic [AW-1:0] addr, input logic [VW-1:0] wdata);
    if (path) begin
      b_req = on; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = on; a_we = we; a_addr = addr; a_wdata = wdata;
    end
  endtask

  task automatic drop_req(input bit path);
    if (path) b_req = 1'b0;
    else      a_req = 1'b0;
  endtask

  // delay < 0 means core_ready never comes (only used with the timeout build).
  task automatic do_txn(input bit path, input bit we, input logic [AW-1:0] addr,
                        input logic [VW-1:0] wdata, input int delay,
                        input logic [VW-1:0] rdata, input bit drop_mid);
    sb_t e, got;
    int  acc;
    int  exp_acc;
    bit  seen;
    logic [VW-1:0] rd_exp;
    rd_exp  = (delay < 0) ? '0 : rdata;
    exp_acc = (delay < 0) ? TO : delay + 1;
    if (!we) begin
      if (path) exp_b_rdata = rd_exp;
      else      exp_a_rdata = rd_exp;
    end
    e.path  = path;
    e.rdata = path ? exp_b_rdata : exp_a_rdata;
    @(negedge clk);
    sb.push_back(e);
    drive_req(path, 1'b1, we, addr, wdata);
    acc  = 0;
    seen = 0;
    for (int cyc = 1; cyc <= 400 && !seen; cyc++) begin
      @(negedge clk);
      if (a_done || b_done) begin
        seen = 1;
        got  = sb.pop_front();
        chk("done_path", {63'd0, b_done}, {63'd0, got.path});
        chk("done_both", {63'd0, a_done & b_done}, 64'd0);
        chk("done_rdata", path ? b_rdata : a_rdata, got.rdata);
        chk("other_rdata", path ? a_rdata : b_rdata, path ? exp_a_rdata : exp_b_rdata);
        chk("access_cycles", acc, exp_acc);
        chk("latency", cyc, acc + 1);
        chk("idle_core_en", {63'd0, core_en}, 64'd0);
        chk("idle_core_addr", core_addr, 64'd0);
        chk("idle_core_wdata", core_wdata, 64'd0);
        drop_req(path);
        core_ready = 1'b0;
      end else if (core_en) begin
        acc++;
        chk("core_we", {63'd0, core_we}, {63'd0, we});
        chk("core_addr", core_addr, addr);
        chk("core_wdata", core_wdata, wdata);
        core_ready = (delay >= 0) && (acc > delay);
        core_rdata = core_ready ? rdata : 32'hBAD0_0000 + acc;
        if (drop_mid && acc == 1) drop_req(path);
      end
    end
    chk("done_seen", {63'd0, seen}, 64'd1);
    @(negedge clk);
    chk("done_one_cycle", {62'd0, a_done, b_done}, 64'd0);
  endtask

  int na, nb, acc_r;
  bit hit;
  sb_t got_t;

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    core_ready = 0; core_rdata = '0; timeout_clr = 0;

    repeat (2) @(negedge clk);
    chk("rst_core_en", {63'd0, core_en}, 64'd0);
    chk("rst_done", {62'd0, a_done, b_done}, 64'd0);
    chk("rst_core_addr", core_addr, 64'd0);
    chk("rst_a_rdata", a_rdata, 64'd0);
    chk("rst_b_rdata", b_rdata, 64'd0);
    chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
    rst_n = 1'b1;

    do_txn(1'b0, 1'b1, 24'h000010, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    do_txn(1'b0, 1'b0, 24'h000020, 32'h0, 1, 32'hCAFEF00D, 1'b0);
    do_txn(1'b1, 1'b0, 24'h000030, 32'h0, 2, 32'h12345678, 1'b0);
    chk("a_rdata_held", a_rdata, 32'hCAFEF00D);
    do_txn(1'b1, 1'b1, 24'h000040, 32'h000055AA, 0, 32'h0, 1'b1);
    chk("b_rdata_after_write", b_rdata, 32'h12345678);
    do_txn(1'b0, 1'b1, 24'h000050, 32'h00000001, 0, 32'h0, 1'b0);

    // Reset in the 2nd ACCESS cycle of an A read that the core never answers.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 24'h000060, 32'h0);
    acc_r = 0;
    for (int i = 0; i < 20 && acc_r < 2; i++) begin
      @(negedge clk);
      if (core_en) acc_r++;
    end
    chk("rst_mid_reached", acc_r, 2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_core_en", {63'd0, core_en}, 64'd0);
    chk("rst_mid_a_rdata", a_rdata, 64'd0);
    chk("rst_mid_b_rdata", b_rdata, 64'd0);
    exp_a_rdata = '0;
    exp_b_rdata = '0;
    @(negedge clk);
    a_req = 1'b0;
    rst_n = 1'b1;
    hit = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_done || b_done || core_en) hit = 1;
    end
    chk("rst_mid_no_done", {63'd0, hit}, 64'd0);

    // Tie: both held for two transactions each; order must be A,B,A,B.
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      got_t.path  = k[0];
      got_t.rdata = '0;
      sb.push_back(got_t);
    end
    drive_req(1'b0, 1'b1, 1'b1, 24'h000A00, 32'hA0A0A0A0);
    drive_req(1'b1, 1'b1, 1'b1, 24'h000B00, 32'hB0B0B0B0);
    na = 0; nb = 0;
    for (int i = 0; i < 60 && (na + nb) < 4; i++) begin
      @(negedge clk);
      if (a_done || b_done) begin
        got_t = sb.pop_front();
        chk("tie_order", {62'd0, a_done, b_done}, got_t.path ? 64'd1 : 64'd2);
        chk("tie_rdata", b_done ? b_rdata : a_rdata, got_t.rdata);
        if (a_done) na++;
        if (b_done) nb++;
        if (na == 2) a_req = 1'b0;
        if (nb == 2) b_req = 1'b0;
      end
      core_ready = core_en;
    end
    chk("tie_count_a", na, 2);
    chk("tie_count_b", nb, 2);
    core_ready = 1'b0;
    @(negedge clk);

`ifdef COMMS_ARB_TIMEOUT_EN
    do_txn(1'b0, 1'b0, 24'h000070, 32'h0, -1, 32'h0, 1'b0);
    chk("to_err_set", {63'd0, timeout_err}, 64'd1);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", {63'd0, timeout_err}, 64'd1);
    timeout_clr = 1'b1;
    do_txn(1'b1, 1'b0, 24'h000080, 32'h0, -1, 32'h0, 1'b0);
    chk("to_set_wins", {63'd0, timeout_err}, 64'd1);
    timeout_clr = 1'b0;
    @(negedge clk);
    chk("to_err_hold", {63'd0, timeout_err}, 64'd1);
    timeout_clr = 1'b1;
    @(negedge clk);
    timeout_clr = 1'b0;
    chk("to_err_clr", {63'd0, timeout_err}, 64'd0);
`else
    timeout_clr = 1'b1;
    do_txn(1'b1, 1'b0, 24'h000090, 32'h0, 100, 32'h0BADF00D, 1'b0);
    timeout_clr = 1'b0;
    chk("long_no_abort_err", {63'd0, timeout_err}, 64'd0);
`endif

    chk("sb_empty", sb.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
